// File: rtl/sw_time_core_if.sv
// Control pulses and display/status outputs of the stopwatch core.
// The controller drives the pulses; the core drives segments and status.
interface sw_time_core_if;
  logic       i_start_stop;
  logic       i_clear;
  logic       i_lap;
  logic [7:0] o_segout1;
  logic [7:0] o_segout2;
  logic [7:0] o_segout3;
  logic [7:0] o_segout4;
  logic [7:0] o_segout5;
  logic [7:0] o_segout6;
  logic       o_running;
  logic       o_lap_active;
  logic       o_rollover;

  modport master (
    output i_start_stop, i_clear, i_lap,
    input  o_segout1, o_segout2, o_segout3, o_segout4, o_segout5, o_segout6,
    input  o_running, o_lap_active, o_rollover
  );

  modport slave (
    input  i_start_stop, i_clear, i_lap,
    output o_segout1, o_segout2, o_segout3, o_segout4, o_segout5, o_segout6,
    output o_running, o_lap_active, o_rollover
  );
endinterface

// File: rtl/sw_time_core.sv
// Stopwatch core: MM:SS.hh BCD count with run/pause, clear and lap freeze,
// driving six registered active-low 7-segment codes for the display mux.
module sw_time_core #(
  parameter int CYCLES_PER_TICK = 1000000
) (
  input logic         i_sys_clk,
  input logic         i_reset_n,
  sw_time_core_if.slave bus
);

  localparam int PW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_TICK - 1);
  // Per-digit maximum, packed like the count: mt mu st su ht hu
  localparam logic [23:0] DIGIT_MAX = 24'h595999;
  localparam logic [47:0] RST_SEG   = 48'hC040_C040_C0C0;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t        state_p0, state_nxt;
  logic          run_en;
  logic          ss_evt, lap_evt, clr_evt;
  logic          tick, wrap;
  logic [PW-1:0] presc_p0, presc_nxt;
  logic [23:0]   cnt_p0, cnt_nxt, cnt_inc;
  logic [23:0]   snap_p0, snap_nxt, disp;
  logic          freeze_p0, freeze_nxt;
  logic          roll_p0, roll_nxt;
  logic [47:0]   seg_p1, seg_nxt;

  function automatic logic [7:0] seg_enc(input logic [3:0] d, input logic dp);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return {~dp, c};
  endfunction

  // Decimal points sit after seconds units and minutes units.
  function automatic logic [47:0] seg_all(input logic [23:0] t);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = seg_enc(t[i*4 +: 4], (i == 2) || (i == 4));
    return r;
  endfunction

  // Ripple a tick through the digit chain; returns {wrap, next count}.
  function automatic logic [24:0] bcd_advance(input logic [23:0] t, input logic inc);
    logic [23:0] r;
    logic        c;
    logic [3:0]  d;
    logic [3:0]  lim;
    r = t;
    c = inc;
    for (int i = 0; i < 6; i++) begin
      d   = t[i*4 +: 4];
      lim = DIGIT_MAX[i*4 +: 4];
      if (c) begin
        if (d >= lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Clear dominates start/stop, which dominates lap.
  assign clr_evt = bus.i_clear;
  assign ss_evt  = bus.i_start_stop & ~bus.i_clear;
  assign lap_evt = bus.i_lap & ~bus.i_clear & ~bus.i_start_stop;

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_p0 <= IDLE;
    else            state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    if (clr_evt) begin
      state_nxt = IDLE;
    end else if (ss_evt) begin
      case (state_p0)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    run_en = 1'b0;
    if (state_p0 == RUN) run_en = 1'b1;
  end

  // ---- stage p0: prescaler, BCD count, lap snapshot ----
  assign tick             = run_en && (presc_p0 == PRESC_LAST);
  assign {wrap, cnt_inc}  = bcd_advance(cnt_p0, tick);
  assign disp             = freeze_p0 ? snap_p0 : cnt_p0;

  always_comb begin
    presc_nxt  = presc_p0;
    cnt_nxt    = cnt_inc;
    snap_nxt   = snap_p0;
    freeze_nxt = freeze_p0;
    roll_nxt   = wrap;
    seg_nxt    = seg_all(disp);
    if (clr_evt) begin
      presc_nxt  = '0;
      cnt_nxt    = '0;
      snap_nxt   = '0;
      freeze_nxt = 1'b0;
      roll_nxt   = 1'b0;
      seg_nxt    = RST_SEG;
    end else begin
      if (run_en) presc_nxt = tick ? '0 : presc_p0 + PW'(1);
      if (lap_evt) begin
        if (freeze_p0 && (state_p0 != IDLE)) begin
          freeze_nxt = 1'b0;
        end else if (!freeze_p0 && run_en) begin
          snap_nxt   = cnt_p0;
          freeze_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_p0  <= '0;
      cnt_p0    <= '0;
      snap_p0   <= '0;
      freeze_p0 <= 1'b0;
      roll_p0   <= 1'b0;
      seg_p1    <= RST_SEG;
    end else begin
      presc_p0  <= presc_nxt;
      cnt_p0    <= cnt_nxt;
      snap_p0   <= snap_nxt;
      freeze_p0 <= freeze_nxt;
      roll_p0   <= roll_nxt;
      seg_p1    <= seg_nxt;
    end
  end

  // ---- stage p1: registered segment codes ----
  assign bus.o_segout1    = seg_p1[7:0];
  assign bus.o_segout2    = seg_p1[15:8];
  assign bus.o_segout3    = seg_p1[23:16];
  assign bus.o_segout4    = seg_p1[31:24];
  assign bus.o_segout5    = seg_p1[39:32];
  assign bus.o_segout6    = seg_p1[47:40];
  assign bus.o_running    = run_en;
  assign bus.o_lap_active = freeze_p0;
  assign bus.o_rollover   = roll_p0;

endmodule

// File: tb/tb_sw_time_core.sv
// Scoreboard bench for sw_time_core with a hundredths-integer reference model.
module tb_sw_time_core;
  localparam int CPT = 4;
  localparam logic [47:0] ZERO_SEG = 48'hC040_C040_C0C0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sw_time_core_if bus ();
  sw_time_core #(.CYCLES_PER_TICK(CPT)) dut (
    .i_sys_clk (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [50:0] sb[$];

  int   m_state, m_presc, m_cnt, m_snap;
  bit   m_freeze, m_roll;
  logic [47:0] m_seg;
  logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] model_segs(input int v);
    int d[6];
    logic [47:0] r;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = (v / 1000) % 6;
    d[4] = (v / 6000) % 10;
    d[5] = v / 60000;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = {((i == 2) || (i == 4)) ? 1'b0 : 1'b1, seg_tbl[d[i]]};
    return r;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_presc = 0; m_cnt = 0; m_snap = 0;
    m_freeze = 0; m_roll = 0;
    m_seg = model_segs(0);
  endfunction

  function automatic void model_step(input bit ss, input bit clr, input bit lp);
    int d;
    bit tk;
    if (clr) begin
      model_reset();
      return;
    end
    d  = m_freeze ? m_snap : m_cnt;
    tk = (m_state == 1) && (m_presc == CPT - 1);
    m_roll = tk && (m_cnt == 359999);
    if (lp && !ss) begin
      if (m_freeze) m_freeze = 0;
      else if (m_state == 1) begin m_snap = m_cnt; m_freeze = 1; end
    end
    if (m_state == 1) m_presc = tk ? 0 : m_presc + 1;
    if (tk) m_cnt = (m_cnt + 1) % 360000;
    if (ss) m_state = (m_state == 1) ? 2 : 1;
    m_seg = model_segs(d);
  endfunction

  function automatic logic [50:0] dut_vec();
    return {bus.o_segout6, bus.o_segout5, bus.o_segout4, bus.o_segout3, bus.o_segout2,
            bus.o_segout1, bus.o_running, bus.o_lap_active, bus.o_rollover};
  endfunction

  function automatic logic [47:0] dut_segs();
    return {bus.o_segout6, bus.o_segout5, bus.o_segout4, bus.o_segout3, bus.o_segout2, bus.o_segout1};
  endfunction

  task automatic cyc(input bit ss, input bit clr, input bit lp);
    logic [50:0] e;
    bus.i_start_stop = ss;
    bus.i_clear      = clr;
    bus.i_lap        = lp;
    model_step(ss, clr, lp);
    sb.push_back({m_seg, (m_state == 1), m_freeze, m_roll});
    @(posedge clk);
    #1;
    bus.i_start_stop = 1'b0;
    bus.i_clear      = 1'b0;
    bus.i_lap        = 1'b0;
    e = sb.pop_front();
    chk("cycle", 64'(dut_vec()), 64'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i_start_stop = 1'b0;
    bus.i_clear      = 1'b0;
    bus.i_lap        = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk("reset_vec", 64'(dut_vec()), 64'({ZERO_SEG, 3'b000}));
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle after reset
    repeat (100) cyc(0, 0, 0);
    chk("idle_seg1", 64'(bus.o_segout1), 64'hC0);
    chk("idle_seg2", 64'(bus.o_segout2), 64'hC0);
    chk("idle_seg3", 64'(bus.o_segout3), 64'h40);
    chk("idle_seg4", 64'(bus.o_segout4), 64'hC0);
    chk("idle_seg5", 64'(bus.o_segout5), 64'h40);
    chk("idle_seg6", 64'(bus.o_segout6), 64'hC0);
    chk("idle_run",  64'(bus.o_running), 64'h0);

    // Start, ten ticks
    cyc(1, 0, 0);
    repeat (41) cyc(0, 0, 0);
    chk("ten_seg2", 64'(bus.o_segout2), 64'hF9);
    chk("ten_seg1", 64'(bus.o_segout1), 64'hC0);
    chk("ten_run",  64'(bus.o_running), 64'h1);

    // Carry 00:00.99 -> 00:01.00
    n = 0;
    while (m_cnt != 100 && n < 2000) begin cyc(0, 0, 0); n++; end
    cyc(0, 0, 0);
    chk("carry_seg3", 64'(bus.o_segout3), 64'h79);
    chk("carry_seg2", 64'(bus.o_segout2), 64'hC0);
    chk("carry_seg1", 64'(bus.o_segout1), 64'hC0);

    // Lap freeze at 00:01.23
    n = 0;
    while (!(m_cnt == 123 && m_presc == 0) && n < 2000) begin cyc(0, 0, 0); n++; end
    cyc(0, 0, 1);
    repeat (20) cyc(0, 0, 0);
    chk("lap_frozen", 64'(dut_segs()), 64'(48'hC040_C079_A4B0));
    chk("lap_active", 64'(bus.o_lap_active), 64'h1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("lap_release", 64'(dut_segs()), 64'(model_segs(128)));
    chk("lap_off", 64'(bus.o_lap_active), 64'h0);
    cyc(0, 0, 1);
    chk("lap_pause_ignored", 64'(bus.o_lap_active), 64'h0);

    // Rollover from a preloaded 59:59.96
    force dut.cnt_p0 = 24'h595996;
    m_cnt = 359996;
    cyc(0, 0, 0);
    release dut.cnt_p0;
    cyc(1, 0, 0);
    n = 0;
    while (bus.o_rollover !== 1'b1 && n < 100) begin cyc(0, 0, 0); n++; end
    chk("roll_hi", 64'(bus.o_rollover), 64'h1);
    cyc(0, 0, 0);
    chk("roll_lo", 64'(bus.o_rollover), 64'h0);
    chk("roll_zero", 64'(dut_segs()), 64'(ZERO_SEG));
    repeat (8) cyc(0, 0, 0);
    chk("roll_continue", 64'(bus.o_segout1), 64'hA4);

    // start_stop together with clear while running
    cyc(1, 1, 0);
    chk("clr_run", 64'(bus.o_running), 64'h0);
    chk("clr_segs", 64'(dut_segs()), 64'(ZERO_SEG));
    cyc(0, 0, 1);
    chk("lap_idle_ignored", 64'(bus.o_lap_active), 64'h0);

    // Asynchronous reset mid-count
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 64'(dut_vec()), 64'({ZERO_SEG, 3'b000}));
    model_reset();
    @(posedge clk);
    #1 chk("async_hold", 64'(dut_vec()), 64'({ZERO_SEG, 3'b000}));
    #2 rst_n = 1'b1;
    cyc(1, 0, 0);
    repeat (9) cyc(0, 0, 0);

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
